// File: rtl/frame_update_scheduler_if.sv
// Handshake bundle between the per-frame update scheduler and the game-logic blocks it sequences.
// The master side drives frame events and done strobes; the slave side (the scheduler) returns ticks and status.
interface frame_update_scheduler_if;
   logic        i_frame_start;
   logic        i_pause;
   logic        i_game_over;
   logic        o_player_tick;
   logic        i_player_done;
   logic        o_invaders_tick;
   logic        i_invaders_done;
   logic        o_gameplay_tick;
   logic        i_gameplay_done;
   logic        o_busy;
   logic [15:0] o_frame_count;
   logic        o_overrun;
   logic        o_timeout;

   modport master (
      output i_frame_start, i_pause, i_game_over,
      output i_player_done, i_invaders_done, i_gameplay_done,
      input  o_player_tick, o_invaders_tick, o_gameplay_tick,
      input  o_busy, o_frame_count, o_overrun, o_timeout
   );

   modport slave (
      input  i_frame_start, i_pause, i_game_over,
      input  i_player_done, i_invaders_done, i_gameplay_done,
      output o_player_tick, o_invaders_tick, o_gameplay_tick,
      output o_busy, o_frame_count, o_overrun, o_timeout
   );
endinterface

// File: rtl/frame_update_scheduler.sv
// Per-frame game-logic sequencer: on each accepted frame start it ticks player, invaders (every
// INVADER_DIV frames, unless game over) and gameplay in order, waiting on each done with a timeout.
module frame_update_scheduler #(
   parameter int INVADER_DIV = 30,
   parameter int TIMEOUT     = 255
) (
   input  logic                     i_clk_36MHz,
   input  logic                     i_reset,
   frame_update_scheduler_if.slave  bus
);

   localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int DIV_W = (INVADER_DIV > 1) ? $clog2(INVADER_DIV) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(INVADER_DIV - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PLAYER   = 2'd1,
      INVADERS = 2'd2,
      GAMEPLAY = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              player_tick_q, player_tick_d;
   logic              invaders_tick_q, invaders_tick_d;
   logic              gameplay_tick_q, gameplay_tick_d;
   logic              busy_q, busy_d;
   logic [15:0]       frame_count_q, frame_count_d;
   logic              overrun_q, overrun_d;
   logic              timeout_q, timeout_d;

   logic              stage_done;
   logic              expired;
   logic              advance;

   // Only the done of the stage currently being waited on is honoured.
   always_comb begin
      stage_done = 1'b0;
      case (state_q)
         PLAYER:   stage_done = bus.i_player_done;
         INVADERS: stage_done = bus.i_invaders_done;
         GAMEPLAY: stage_done = bus.i_gameplay_done;
         default:  stage_done = 1'b0;
      endcase
   end

   // The last permitted cycle in a stage forces the advance when no done has shown up.
   assign expired = (state_q != IDLE) && !stage_done && (timer_q == TMR_LAST);
   assign advance = stage_done || expired;

   always_comb begin
      state_d         = state_q;
      timer_d         = timer_q;
      div_d           = div_q;
      player_tick_d   = 1'b0;
      invaders_tick_d = 1'b0;
      gameplay_tick_d = 1'b0;
      frame_count_d   = frame_count_q;
      overrun_d       = overrun_q;
      timeout_d       = timeout_q;

      case (state_q)
         IDLE: begin
            timer_d = '0;
            if (bus.i_frame_start && !bus.i_pause) begin
               frame_count_d = frame_count_q + 16'd1;
               state_d       = PLAYER;
               player_tick_d = 1'b1;
            end
         end

         PLAYER: begin
            timer_d = timer_q + TMR_W'(1);
            if (advance) begin
               timer_d = '0;
               // The divider counts completed player stages even when invaders are skipped.
               if (div_q == DIV_LAST) begin
                  div_d = '0;
                  if (!bus.i_game_over) begin
                     state_d         = INVADERS;
                     invaders_tick_d = 1'b1;
                  end else begin
                     state_d         = GAMEPLAY;
                     gameplay_tick_d = 1'b1;
                  end
               end else begin
                  div_d           = div_q + DIV_W'(1);
                  state_d         = GAMEPLAY;
                  gameplay_tick_d = 1'b1;
               end
            end
         end

         INVADERS: begin
            timer_d = timer_q + TMR_W'(1);
            if (advance) begin
               timer_d         = '0;
               state_d         = GAMEPLAY;
               gameplay_tick_d = 1'b1;
            end
         end

         GAMEPLAY: begin
            timer_d = timer_q + TMR_W'(1);
            if (advance) begin
               timer_d = '0;
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
            timer_d = '0;
         end
      endcase

      if (expired) begin
         timeout_d = 1'b1;
      end

      // A frame start while a sequence is running is dropped and flagged, including on the final edge.
      if (bus.i_frame_start && (state_q != IDLE)) begin
         overrun_d = 1'b1;
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge i_clk_36MHz) begin
      if (!i_reset) begin
         state_q         <= IDLE;
         timer_q         <= '0;
         div_q           <= '0;
         player_tick_q   <= 1'b0;
         invaders_tick_q <= 1'b0;
         gameplay_tick_q <= 1'b0;
         busy_q          <= 1'b0;
         frame_count_q   <= 16'd0;
         overrun_q       <= 1'b0;
         timeout_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         timer_q         <= timer_d;
         div_q           <= div_d;
         player_tick_q   <= player_tick_d;
         invaders_tick_q <= invaders_tick_d;
         gameplay_tick_q <= gameplay_tick_d;
         busy_q          <= busy_d;
         frame_count_q   <= frame_count_d;
         overrun_q       <= overrun_d;
         timeout_q       <= timeout_d;
      end
   end

   assign bus.o_player_tick   = player_tick_q;
   assign bus.o_invaders_tick = invaders_tick_q;
   assign bus.o_gameplay_tick = gameplay_tick_q;
   assign bus.o_busy          = busy_q;
   assign bus.o_frame_count   = frame_count_q;
   assign bus.o_overrun       = overrun_q;
   assign bus.o_timeout       = timeout_q;

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Randomized scoreboard bench for frame_update_scheduler: frames are planned as stage intervals,
// expected ticks are queued at planning time and a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_frame_update_scheduler;

   localparam int DIV = 3;
   localparam int TMO = 8;

   logic   clk = 1'b0;
   logic   rst_n = 1'b0;
   longint cyc = 0;
   bit     mon_en = 1'b0;
   int     n_checks = 0;
   int     n_fail = 0;

   typedef struct {
      int     kind;
      longint edge_i;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] exp_count = 16'd0;
   logic        exp_ovr = 1'b0;
   logic        exp_to = 1'b0;
   int          pdone = 0;

   frame_update_scheduler_if bus();

   frame_update_scheduler #(.INVADER_DIV(DIV), .TIMEOUT(TMO)) dut (
      .i_clk_36MHz (clk),
      .i_reset     (rst_n),
      .bus         (bus)
   );

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
      end
   endtask

   function automatic longint mn(input longint a, input longint b);
      return (a < b) ? a : b;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_tick(input int kind, input longint e);
      exp_t x;
      x.kind   = kind;
      x.edge_i = e;
      sb.push_back(x);
   endtask

   task automatic model_reset();
      exp_count = 16'd0;
      exp_ovr   = 1'b0;
      exp_to    = 1'b0;
      pdone     = 0;
   endtask

   task automatic chk_status(input logic busy_exp);
      chk("busy", bus.o_busy, busy_exp);
      chk("frame_count", bus.o_frame_count, exp_count);
      chk("overrun", bus.o_overrun, exp_ovr);
      chk("timeout", bus.o_timeout, exp_to);
   endtask

   task automatic do_reset(input int k);
      rst_n = 1'b0;
      repeat (k) begin
         bus.i_frame_start   = 1'($urandom_range(0, 1));
         bus.i_pause         = 1'($urandom_range(0, 1));
         bus.i_game_over     = 1'($urandom_range(0, 1));
         bus.i_player_done   = 1'($urandom_range(0, 1));
         bus.i_invaders_done = 1'($urandom_range(0, 1));
         bus.i_gameplay_done = 1'($urandom_range(0, 1));
         step();
         mon_en = 1'b1;
         model_reset();
         chk("reset_ticks", {bus.o_player_tick, bus.o_invaders_tick, bus.o_gameplay_tick}, 3'b000);
         chk_status(1'b0);
      end
      rst_n = 1'b1;
   endtask

   // fs_mode: 0 no frame starts, 1 random paused frame starts, 2 a paused frame start every cycle.
   task automatic idle(input int k, input int fs_mode, input bit force_gdone);
      repeat (k) begin
         bus.i_frame_start   = (fs_mode == 2) ? 1'b1 : (fs_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.i_pause         = 1'b1;
         bus.i_game_over     = 1'($urandom_range(0, 1));
         bus.i_player_done   = 1'($urandom_range(0, 1));
         bus.i_invaders_done = 1'($urandom_range(0, 1));
         bus.i_gameplay_done = force_gdone ? 1'b1 : 1'($urandom_range(0, 1));
         step();
         chk_status(1'b0);
      end
   endtask

   // dp/di/dg: cycles after each tick at which that stage's done is raised (>= TMO means never).
   // ovr_mode: 0 none, 1 extra frame start anywhere in the sequence, 2 during gameplay.
   task automatic run_frame(input int dp, input int di, input int dg, input bit go,
                            input int ovr_mode, input bit abort);
      longint n, e1, e2, e3, ovr, ab, last;
      bit     inv, to1, to2, to3;
      logic   base_ovr, base_to;
      n   = cyc + 1;
      e1  = n + 1 + mn(dp, TMO - 1);
      to1 = (dp >= TMO);
      pdone++;
      inv = ((pdone % DIV) == 0) && !go;
      e2  = e1;
      to2 = 1'b0;
      if (inv) begin
         e2  = e1 + 1 + mn(di, TMO - 1);
         to2 = (di >= TMO);
      end
      e3  = e2 + 1 + mn(dg, TMO - 1);
      to3 = (dg >= TMO);
      ovr = -1;
      if (ovr_mode == 1) ovr = n + 1 + $urandom_range(0, int'(e3 - n - 1));
      if (ovr_mode == 2) ovr = e2 + 1 + $urandom_range(0, int'(e3 - e2 - 1));
      ab   = abort ? e2 + 1 : -1;
      last = abort ? ab : e3;
      push_tick(0, n);
      if (inv) push_tick(1, e1);
      push_tick(2, e2);
      exp_count = exp_count + 16'd1;
      base_ovr  = exp_ovr;
      base_to   = exp_to;
      for (longint t = n; t <= last; t++) begin
         logic ap, ai, ag;
         ap = (t >= n + 1) && (t <= e1);
         ai = inv && (t >= e1 + 1) && (t <= e2);
         ag = (t >= e2 + 1) && (t <= e3);
         bus.i_frame_start   = (t == n) || (t == ovr);
         bus.i_pause         = (t == n) ? 1'b0 : 1'($urandom_range(0, 1));
         bus.i_game_over     = go;
         bus.i_player_done   = ap ? (t == n + 1 + dp) : 1'($urandom_range(0, 1));
         bus.i_invaders_done = ai ? (t == e1 + 1 + di) : 1'($urandom_range(0, 1));
         bus.i_gameplay_done = ag ? (t == e2 + 1 + dg) : 1'($urandom_range(0, 1));
         rst_n = !(abort && (t == ab));
         step();
         if (abort && (t == ab)) begin
            model_reset();
            chk_status(1'b0);
         end else begin
            exp_to  = base_to | (to1 && t >= e1) | (to2 && t >= e2) | (to3 && t >= e3);
            exp_ovr = base_ovr | ((ovr >= 0) && (t >= ovr));
            chk_status(t < e3);
         end
      end
      rst_n = 1'b1;
   endtask

   // Monitor: every tick the DUT presents is matched against the oldest queued expectation.
   always @(negedge clk) begin
      int   nt;
      int   kind;
      exp_t e;
      if (mon_en) begin
         nt = int'(bus.o_player_tick) + int'(bus.o_invaders_tick) + int'(bus.o_gameplay_tick);
         if (nt > 1) begin
            chk("one_tick_at_a_time", nt, 1);
         end else if (nt == 1) begin
            kind = bus.o_player_tick ? 0 : (bus.o_invaders_tick ? 1 : 2);
            if (sb.size() == 0) begin
               chk("unexpected_tick_kind_plus1", kind + 1, 0);
            end else begin
               e = sb.pop_front();
               chk("tick_kind", kind, e.kind);
               chk("tick_cycle", cyc, e.edge_i);
            end
         end
      end
   end

   initial begin
      bus.i_frame_start   = 1'b0;
      bus.i_pause         = 1'b0;
      bus.i_game_over     = 1'b0;
      bus.i_player_done   = 1'b0;
      bus.i_invaders_done = 1'b0;
      bus.i_gameplay_done = 1'b0;

      do_reset(3);

      // Six frames, dones two cycles after each tick: invaders on frames 3 and 6 only.
      repeat (6) begin
         run_frame(2, 2, 2, 1'b0, 0, 1'b0);
         idle(2, 0, 1'b0);
      end

      // Paused frame starts are dropped; only the unpaused one runs.
      do_reset(1);
      idle(1, 0, 1'b0);
      idle(1, 2, 1'b0);
      idle(2, 0, 1'b0);
      idle(1, 2, 1'b0);
      idle(1, 0, 1'b0);
      run_frame(1, 1, 1, 1'b0, 0, 1'b0);
      idle(3, 0, 1'b0);

      // Player done withheld: stage times out.
      run_frame(30, 1, 1, 1'b0, 0, 1'b0);
      idle(2, 0, 1'b0);

      // Second frame start during gameplay.
      run_frame(0, 0, 3, 1'b0, 2, 1'b0);
      idle(2, 0, 1'b0);

      // Minimum sequence and back-to-back frames.
      run_frame(0, 0, 0, 1'b1, 0, 1'b0);
      run_frame(0, 0, 0, 1'b1, 0, 1'b0);
      idle(1, 0, 1'b0);

      // Game over suppresses invaders; then reset mid-gameplay with a late done afterwards.
      do_reset(2);
      repeat (4) begin
         run_frame($urandom_range(0, 3), 0, 1, 1'b1, 0, 1'b0);
         idle(1, 0, 1'b0);
      end
      run_frame(1, 0, 4, 1'b1, 0, 1'b1);
      idle(2, 0, 1'b1);
      run_frame(0, 0, 0, 1'b0, 0, 1'b0);
      idle(2, 0, 1'b0);

      // Randomized frames with random stage latencies, overruns and paused gaps.
      repeat (40) begin
         run_frame($urandom_range(0, 10), $urandom_range(0, 10), $urandom_range(0, 10),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 1 : 0, 1'b0);
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 4), 1, 1'b0);
      end
      idle(4, 0, 1'b0);

      chk("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
